// File: rtl/link_power_source.sv
`default_nettype none
// ============================================================================
//  Module   : link_power_source
//  Purpose  : Power-sourcing end of a pair-powered link. Two-point signature
//             detection, classification, timed inrush with overload watch,
//             and powered-state monitoring for overload and disconnect.
//  Revision : 1.0 - initial release
// ============================================================================
module link_power_source #(
  parameter int SETTLE_CYCLES     = 16,
  parameter int DELTA_MIN         = 40,
  parameter int DELTA_MAX         = 120,
  parameter int CLASS_T1          = 20,
  parameter int CLASS_T2          = 60,
  parameter int CLASS_T3          = 100,
  parameter int CLASS_T4          = 140,
  parameter int INRUSH_CYCLES     = 64,
  parameter int HOLD_CODE         = 8,
  parameter int DISCONNECT_CYCLES = 32,
  parameter int OVERLOAD_CODE     = 900,
  parameter int BACKOFF_CYCLES    = 128
) (
  input  logic       Clock100Mhz,
  input  logic       ResetN,
  input  logic       Enable,
  input  logic       SenseValid,
  input  logic [9:0] SenseCode,
  output logic [1:0] DetectDrive,
  output logic       ClassDrive,
  output logic       PowerOn,
  output logic [2:0] PdClass,
  output logic [2:0] State,
  output logic       Fault
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DET1    = 3'd1,
    ST_DET2    = 3'd2,
    ST_CLASS   = 3'd3,
    ST_INRUSH  = 3'd4,
    ST_POWERED = 3'd5,
    ST_BACKOFF = 3'd6
  } state_t;

  // One shared phase counter; sized for the longest timed phase.
  localparam int CNT_MAX_A = (SETTLE_CYCLES > INRUSH_CYCLES) ? SETTLE_CYCLES : INRUSH_CYCLES;
  localparam int CNT_MAX_B = (DISCONNECT_CYCLES > BACKOFF_CYCLES) ? DISCONNECT_CYCLES : BACKOFF_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CW        = $clog2(CNT_MAX + 1);

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [9:0]         s1, s1_nx;
  logic [2:0]         pd_class_nx;
  logic               fault_nx;
  logic [1:0]         detect_nx;
  logic               class_drive_nx;
  logic               power_nx;
  logic               settled;
  logic               probe_ok;
  logic               overload;
  logic               hold;
  logic signed [10:0] delta;
  logic               sig_ok;

  // A probe sample only counts once the settle counter has saturated.
  assign settled  = (cnt == CW'(SETTLE_CYCLES));
  assign probe_ok = SenseValid && settled;
  assign overload = SenseValid && (SenseCode >= 10'(OVERLOAD_CODE));
  assign hold     = SenseValid && (SenseCode >= 10'(HOLD_CODE));
  // S2 is used straight off the bus so the DET2 decision lands on the sample edge.
  assign delta    = $signed({1'b0, SenseCode}) - $signed({1'b0, s1});
  assign sig_ok   = !delta[10] && (delta >= $signed(11'(DELTA_MIN)))
                               && (delta <= $signed(11'(DELTA_MAX)));
  assign State    = state;

  // Next-state, counter, latched-value and registered-output decode.
  always_comb begin
    state_nx    = state;
    s1_nx       = s1;
    pd_class_nx = PdClass;
    fault_nx    = Fault;
    if (Enable) begin
      case (state)
        ST_IDLE: state_nx = ST_DET1;
        ST_DET1: begin
          if (probe_ok) begin
            s1_nx    = SenseCode;
            state_nx = ST_DET2;
          end
        end
        ST_DET2: begin
          if (probe_ok) state_nx = sig_ok ? ST_CLASS : ST_BACKOFF;
        end
        ST_CLASS: begin
          if (probe_ok) begin
            if (SenseCode < 10'(CLASS_T1))      pd_class_nx = 3'd0;
            else if (SenseCode < 10'(CLASS_T2)) pd_class_nx = 3'd1;
            else if (SenseCode < 10'(CLASS_T3)) pd_class_nx = 3'd2;
            else if (SenseCode < 10'(CLASS_T4)) pd_class_nx = 3'd3;
            else                                pd_class_nx = 3'd4;
            state_nx = ST_INRUSH;
          end
        end
        ST_INRUSH: begin
          if (overload) begin
            fault_nx = 1'b1;
            state_nx = ST_BACKOFF;
          end else if (cnt == CW'(INRUSH_CYCLES - 1)) begin
            state_nx = ST_POWERED;
          end
        end
        ST_POWERED: begin
          // Overload takes priority over a coincident disconnect expiry.
          if (overload) begin
            fault_nx = 1'b1;
            state_nx = ST_BACKOFF;
          end else if (!hold && (cnt == CW'(DISCONNECT_CYCLES - 1))) begin
            state_nx = ST_IDLE;
          end
        end
        ST_BACKOFF: begin
          if (cnt == CW'(BACKOFF_CYCLES - 1)) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end else begin
      state_nx = ST_IDLE;
    end

    if (state == ST_IDLE && state_nx == ST_DET1) fault_nx = 1'b0;

    if (state_nx != state) begin
      cnt_nx = '0;
    end else begin
      case (state)
        ST_DET1, ST_DET2, ST_CLASS: cnt_nx = settled ? cnt : cnt + 1'b1;
        ST_INRUSH, ST_BACKOFF:      cnt_nx = cnt + 1'b1;
        ST_POWERED:                 cnt_nx = hold ? '0 : cnt + 1'b1;
        default:                    cnt_nx = '0;
      endcase
    end

    detect_nx      = (state_nx == ST_DET1) ? 2'd1 :
                     (state_nx == ST_DET2) ? 2'd2 : 2'd0;
    class_drive_nx = (state_nx == ST_CLASS);
    power_nx       = (state_nx == ST_INRUSH) || (state_nx == ST_POWERED);
  end

  // State, counter and output registers; reset drops the drives asynchronously.
  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      s1          <= '0;
      PdClass     <= '0;
      Fault       <= 1'b0;
      DetectDrive <= '0;
      ClassDrive  <= 1'b0;
      PowerOn     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      s1          <= s1_nx;
      PdClass     <= pd_class_nx;
      Fault       <= fault_nx;
      DetectDrive <= detect_nx;
      ClassDrive  <= class_drive_nx;
      PowerOn     <= power_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_link_power_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_link_power_source
//  Purpose  : Self-checking bench for link_power_source. Randomised PD
//             sessions scored against a rule-level model of the source.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_link_power_source;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DET1    = 3'd1;
  localparam logic [2:0] ST_DET2    = 3'd2;
  localparam logic [2:0] ST_CLASS   = 3'd3;
  localparam logic [2:0] ST_INRUSH  = 3'd4;
  localparam logic [2:0] ST_POWERED = 3'd5;
  localparam logic [2:0] ST_BACKOFF = 3'd6;

  localparam int M_DISC   = 0;
  localparam int M_OVL_IN = 1;
  localparam int M_ABORT  = 2;
  localparam int M_RESET  = 3;
  localparam int M_OVL_PW = 4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       sense_valid;
  logic [9:0] sense_code;
  logic [1:0] detect_drive;
  logic       class_drive;
  logic       power_on;
  logic [2:0] pd_class;
  logic [2:0] state;
  logic       fault;

  int   checks    = 0;
  int   failures  = 0;
  logic exp_fault = 1'b0;
  int   exp_class = 0;

  link_power_source dut (
    .Clock100Mhz (clk),
    .ResetN      (rst_n),
    .Enable      (enable),
    .SenseValid  (sense_valid),
    .SenseCode   (sense_code),
    .DetectDrive (detect_drive),
    .ClassDrive  (class_drive),
    .PowerOn     (power_on),
    .PdClass     (pd_class),
    .State       (state),
    .Fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference rules: class = number of thresholds reached; signature valid
  // when the two-point difference sits inside the allowed window.
  function automatic int class_of(input int c);
    int thr [4];
    int n;
    thr = '{20, 60, 100, 140};
    n = 0;
    foreach (thr[i]) if (c >= thr[i]) n++;
    return n;
  endfunction

  function automatic bit sig_ok(input int s1, input int s2);
    int d;
    d = s2 - s1;
    return (d >= 40) && (d <= 120);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle sample strobe; returns on the negedge after the latching edge.
  task automatic pulse(input int code);
    sense_valid = 1'b1;
    sense_code  = 10'(code);
    tick();
    sense_valid = 1'b0;
  endtask

  // Probe phase: an early sample must be ignored, a late one accepted.
  task automatic probe(input int code, input logic [2:0] st, input logic [1:0] drv, input string tag);
    chk({tag, "_state"}, state, st);
    chk({tag, "_detect"}, detect_drive, drv);
    chk({tag, "_classdrv"}, class_drive, st == ST_CLASS);
    chk({tag, "_power"}, power_on, 1'b0);
    repeat (4) tick();
    pulse($urandom_range(0, 1023));
    chk({tag, "_early_ignored"}, state, st);
    repeat (14 + $urandom_range(0, 6)) tick();
    pulse(code);
  endtask

  task automatic backoff_run();
    int   n;
    logic pw;
    n  = 0;
    pw = 1'b0;
    while (state == ST_BACKOFF && n < 400) begin
      pw = pw | power_on;
      n++;
      sense_valid = ($urandom_range(0, 3) == 0);
      sense_code  = 10'($urandom_range(0, 1023));
      tick();
    end
    sense_valid = 1'b0;
    chk("backoff_len", n, 128);
    chk("backoff_power", pw, 1'b0);
    chk("backoff_to_idle", state, ST_IDLE);
    chk("backoff_fault", fault, exp_fault);
    enable = 1'b0;
    tick();
  endtask

  task automatic session(input int s1, input int s2, input int c, input int mode);
    int n;
    chk("idle_fault", fault, exp_fault);
    chk("idle_class", pd_class, exp_class);
    enable = 1'b1;
    tick();
    exp_fault = 1'b0;
    chk("det1_fault_clear", fault, exp_fault);
    probe(s1, ST_DET1, 2'd1, "det1");
    probe(s2, ST_DET2, 2'd2, "det2");
    if (!sig_ok(s1, s2)) begin
      chk("sig_bad_state", state, ST_BACKOFF);
      chk("sig_bad_detect", detect_drive, 2'd0);
      backoff_run();
      return;
    end
    if (mode == M_ABORT) begin
      chk("abort_in_class", state, ST_CLASS);
      repeat (3) tick();
      enable = 1'b0;
      tick();
      chk("abort_state", state, ST_IDLE);
      chk("abort_detect", detect_drive, 2'd0);
      chk("abort_classdrv", class_drive, 1'b0);
      chk("abort_power", power_on, 1'b0);
      tick();
      return;
    end
    probe(c, ST_CLASS, 2'd0, "class");
    exp_class = class_of(c);
    chk("inrush_state", state, ST_INRUSH);
    chk("inrush_power", power_on, 1'b1);
    chk("inrush_classdrv", class_drive, 1'b0);
    chk("pd_class", pd_class, exp_class);
    if (mode == M_OVL_IN) begin
      repeat (9) tick();
      pulse((s1 & 1) ? 950 : $urandom_range(900, 1023));
      exp_fault = 1'b1;
      chk("ovl_in_state", state, ST_BACKOFF);
      chk("ovl_in_fault", fault, 1'b1);
      chk("ovl_in_power", power_on, 1'b0);
      backoff_run();
      return;
    end
    n = 0;
    while (state == ST_INRUSH && n < 200) begin
      n++;
      sense_valid = ($urandom_range(0, 3) == 0);
      sense_code  = 10'($urandom_range(0, 899));
      tick();
    end
    sense_valid = 1'b0;
    chk("inrush_len", n, 64);
    chk("powered_state", state, ST_POWERED);
    chk("powered_power", power_on, 1'b1);
    repeat (3) begin
      repeat (7 + $urandom_range(0, 20)) tick();
      pulse($urandom_range(8, 899));
      chk("powered_hold", state, ST_POWERED);
    end
    if (mode == M_RESET) begin
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_power_async", power_on, 1'b0);
      chk("rst_state", state, ST_IDLE);
      chk("rst_class", pd_class, 3'd0);
      exp_fault = 1'b0;
      exp_class = 0;
      enable    = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      return;
    end
    if (mode == M_OVL_PW) begin
      pulse($urandom_range(900, 1023));
      exp_fault = 1'b1;
      chk("ovl_pw_state", state, ST_BACKOFF);
      chk("ovl_pw_power", power_on, 1'b0);
      backoff_run();
      return;
    end
    // Only sub-hold samples from here: disconnect after exactly 32 edges.
    n = 0;
    while (state == ST_POWERED && n < 100) begin
      sense_valid = ($urandom_range(0, 1) == 1);
      sense_code  = 10'($urandom_range(0, 7));
      tick();
      n++;
    end
    sense_valid = 1'b0;
    chk("disc_latency", n, 32);
    chk("disc_state", state, ST_IDLE);
    chk("disc_power", power_on, 1'b0);
    chk("disc_fault", fault, 1'b0);
    enable = 1'b0;
    tick();
  endtask

  initial begin
    int s1;
    int s2;
    rst_n       = 1'b0;
    enable      = 1'b0;
    sense_valid = 1'b0;
    sense_code  = '0;
    repeat (3) tick();
    chk("reset_state", state, ST_IDLE);
    chk("reset_detect", detect_drive, 2'd0);
    chk("reset_classdrv", class_drive, 1'b0);
    chk("reset_power", power_on, 1'b0);
    chk("reset_class", pd_class, 3'd0);
    chk("reset_fault", fault, 1'b0);
    rst_n = 1'b1;
    tick();

    repeat (6) begin
      sense_valid = 1'b1;
      sense_code  = 10'($urandom_range(0, 1023));
      tick();
    end
    sense_valid = 1'b0;
    chk("idle_disabled", state, ST_IDLE);

    session(100, 180, 70, M_DISC);
    session(100, 300, 70, M_DISC);
    session(100, 90, 70, M_DISC);
    session(100, 180, 19, M_DISC);
    session(100, 180, 20, M_DISC);
    session(100, 180, 139, M_DISC);
    session(100, 180, 140, M_DISC);
    session(100, 180, 70, M_OVL_IN);
    session(200, 239, 50, M_DISC);
    session(200, 240, 110, M_ABORT);
    session(200, 320, 30, M_RESET);
    session(200, 321, 30, M_DISC);
    session(300, 360, 500, M_OVL_PW);

    for (int i = 0; i < 10; i++) begin
      s1 = int'($urandom_range(150, 800));
      s2 = s1 - 20 + int'($urandom_range(0, 160));
      session(s1, s2, int'($urandom_range(0, 300)), int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
